// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write-port bundle for imem_loader.
// The slave modport is the loader side; master is the stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 14
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] adra;
    logic [31:0]           dina;
    logic [3:0]            wea;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport slave (
        input  in_data, in_valid,
        output in_ready, adra, dina, wea, busy, done, error
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, adra, dina, wea, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Parses {base, count, payload[, checksum]} byte streams into masked 32-bit IMEM writes.
// Write issued the cycle after the byte that completes a word; in_ready drops only in END.
// Optional trailing checksum byte enabled by `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic           clk,
    input  logic           reset,
    imem_loader_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_END
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    localparam logic [32:0] CAP = 33'd1 << (ADDR_WIDTH + 2);

    state_t      state;
    logic [55:0] hdr;
    logic [2:0]  hdr_cnt;
    logic [31:0] addr;
    logic [31:0] rem;
    logic [31:0] wbuf;
    logic [3:0]  wmask;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    logic        fire;
    logic [1:0]  lane;
    logic [31:0] buf_next;
    logic [3:0]  mask_next;
    logic [63:0] hdr_full;
    logic        range_bad;

    assign bus.in_ready = !reset && (state != S_END);
    assign fire         = bus.in_valid && bus.in_ready;

    always_comb begin
        lane      = addr[1:0];
        buf_next  = wbuf;
        buf_next[{lane, 3'b000} +: 8] = bus.in_data;
        mask_next = wmask;
        mask_next[lane] = 1'b1;
        hdr_full  = {bus.in_data, hdr};
        // 33-bit sum so a base near 4 GiB cannot wrap past the capacity check
        range_bad = ({1'b0, hdr_full[31:0]} + {1'b0, hdr_full[63:32]}) > CAP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            hdr       <= '0;
            hdr_cnt   <= '0;
            addr      <= '0;
            rem       <= '0;
            wbuf      <= '0;
            wmask     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
            bus.adra  <= '0;
            bus.dina  <= '0;
            bus.wea   <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
        end else begin
            bus.wea   <= '0;
            bus.dina  <= '0;
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        hdr[7:0] <= bus.in_data;
                        hdr_cnt  <= 3'd1;
                        bus.busy <= 1'b1;
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (fire) begin
                        if (hdr_cnt == 3'd7) begin
                            addr  <= hdr_full[31:0];
                            rem   <= hdr_full[63:32];
                            wbuf  <= '0;
                            wmask <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            sum   <= '0;
`endif
                            if (range_bad) begin
                                bus.error <= 1'b1;
                                state     <= S_END;
                            end else if (hdr_full[63:32] == 32'd0) begin
                                bus.done  <= 1'b1;
                                state     <= S_END;
                            end else begin
                                state     <= S_DATA;
                            end
                        end else begin
                            hdr[{hdr_cnt, 3'b000} +: 8] <= bus.in_data;
                            hdr_cnt <= hdr_cnt + 3'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        addr <= addr + 32'd1;
                        rem  <= rem - 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum  <= sum + bus.in_data;
`endif
                        if (lane == 2'd3 || rem == 32'd1) begin
                            bus.adra <= addr[ADDR_WIDTH+1:2];
                            bus.dina <= buf_next;
                            bus.wea  <= mask_next;
                            wbuf     <= '0;
                            wmask    <= '0;
                        end else begin
                            wbuf  <= buf_next;
                            wmask <= mask_next;
                        end
                        if (rem == 32'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= S_CSUM;
`else
                            bus.done <= 1'b1;
                            state    <= S_END;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (fire) begin
                        if (bus.in_data == sum) bus.done  <= 1'b1;
                        else                    bus.error <= 1'b1;
                        state <= S_END;
                    end
                end
`endif
                S_END: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
